// File: rtl/muldiv_seq_if.sv
// Handshake and data bundle between the exec stage and the RV32M multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_write_addr;
  logic            flush;
  logic            stall;
  logic            valid;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_write_addr_out;

  modport master (
    output start, op, rs1_data, rs2_data, rd_write_addr, flush,
    input  stall, valid, result, rd_write_addr_out
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_write_addr, flush,
    output stall, valid, result, rd_write_addr_out
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Operands are reduced to magnitudes on entry; the sign is reapplied on the final iteration.
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);

  localparam int unsigned PW = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              stall_c;

  // Operand decode for an incoming request
  logic            accept_c, is_div_c, sgn1_c, sgn2_c, neg_in_c;
  logic            div_zero_c, div_ovf_c, special_c;
  logic [XLEN-1:0] mag1_c, mag2_c, special_res_c;

  always_comb begin
    accept_c   = (state_q == S_IDLE) && bus.start && !bus.flush;
    is_div_c   = bus.op[2];
    sgn1_c     = bus.rs1_data[XLEN-1] &&
                 (bus.op == OP_MULH || bus.op == OP_MULHSU || bus.op == OP_DIV || bus.op == OP_REM);
    sgn2_c     = bus.rs2_data[XLEN-1] &&
                 (bus.op == OP_MULH || bus.op == OP_DIV || bus.op == OP_REM);
    mag1_c     = sgn1_c ? (XLEN'(0) - bus.rs1_data) : bus.rs1_data;
    mag2_c     = sgn2_c ? (XLEN'(0) - bus.rs2_data) : bus.rs2_data;
    unique case (bus.op)
      OP_MULH, OP_DIV:   neg_in_c = sgn1_c ^ sgn2_c;
      OP_MULHSU, OP_REM: neg_in_c = sgn1_c;
      default:           neg_in_c = 1'b0;
    endcase
    div_zero_c = is_div_c && (bus.rs2_data == '0);
    div_ovf_c  = (bus.op == OP_DIV || bus.op == OP_REM) &&
                 (bus.rs1_data == INT_MIN) && (bus.rs2_data == '1);
    special_c  = div_zero_c || div_ovf_c;
    // op[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero_c) special_res_c = bus.op[1] ? bus.rs1_data : '1;
    else            special_res_c = bus.op[1] ? '0 : INT_MIN;
  end

  // One iteration of each datapath plus sign-corrected final results
  logic [XLEN:0]   mul_sum_c, div_shift_c, div_diff_c;
  logic            div_ok_c;
  logic [PW-1:0]   prod_step_c, prod_fin_c;
  logic [XLEN-1:0] rem_step_c, quo_step_c, rem_fin_c, quo_fin_c, final_res_c;

  always_comb begin
    mul_sum_c   = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : (XLEN+1)'(0));
    prod_step_c = {mul_sum_c, prod_q[XLEN-1:1]};
    div_shift_c = {rem_q, a_q[XLEN-1]};
    div_diff_c  = div_shift_c - {1'b0, b_q};
    div_ok_c    = !div_diff_c[XLEN];
    rem_step_c  = div_ok_c ? div_diff_c[XLEN-1:0] : div_shift_c[XLEN-1:0];
    quo_step_c  = {a_q[XLEN-2:0], div_ok_c};
    prod_fin_c  = neg_q ? (PW'(0) - prod_step_c) : prod_step_c;
    quo_fin_c   = neg_q ? (XLEN'(0) - quo_step_c) : quo_step_c;
    rem_fin_c   = neg_q ? (XLEN'(0) - rem_step_c) : rem_step_c;
    unique case (op_q)
      OP_MUL:             final_res_c = prod_fin_c[XLEN-1:0];
      3'd1, 3'd2, 3'd3:   final_res_c = prod_fin_c[PW-1:XLEN];
      3'd4, 3'd5:         final_res_c = quo_fin_c;
      default:            final_res_c = rem_fin_c;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept_c) state_d = special_c ? S_DONE : S_CALC;
      S_CALC: begin
        if (bus.flush)          state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: registered result/valid next values and combinational stall
  always_comb begin
    valid_d  = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;
    stall_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          stall_c = 1'b1;
          if (special_c) begin
            valid_d  = 1'b1;
            result_d = special_res_c;
            rd_out_d = bus.rd_write_addr;
          end
        end
      end
      S_CALC: begin
        stall_c = 1'b1;
        if (!bus.flush && cnt_q == '0) begin
          valid_d  = 1'b1;
          result_d = final_res_c;
          rd_out_d = rd_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    rd_d   = rd_q;
    neg_d  = neg_q;
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
    rem_d  = rem_q;
    if (accept_c) begin
      cnt_d  = CNT_W'(XLEN - 1);
      op_d   = bus.op;
      rd_d   = bus.rd_write_addr;
      neg_d  = neg_in_c;
      a_d    = mag1_c;
      b_d    = mag2_c;
      prod_d = {XLEN'(0), mag2_c};
      rem_d  = '0;
    end else if (state_q == S_CALC) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      if (op_q[2]) begin
        a_d   = quo_step_c;
        rem_d = rem_step_c;
      end else begin
        prod_d = prod_step_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign bus.stall             = stall_c;
  assign bus.valid             = valid_q;
  assign bus.result            = result_q;
  assign bus.rd_write_addr_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised and directed bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] IMIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();

  muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    r  = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = '1;
        else if (a == IMIN && b == '1) r = IMIN;
        else r = 32'(sa / sb);
      end
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == IMIN && b == '1) r = '0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == IMIN && b == '1) return 1;
    return XLEN + 1;
  endfunction

  task automatic idle_inputs();
    bus.start         = 1'b0;
    bus.flush         = 1'b0;
    bus.op            = '0;
    bus.rs1_data      = '0;
    bus.rs2_data      = '0;
    bus.rd_write_addr = '0;
  endtask

  // Issue one operation at a negedge and follow it to its valid pulse
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int lat, stall_cnt, elat;
    bit got;
    elat = exp_latency(op, a, b);
    bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_write_addr = rd;
    bus.start = 1'b1;
    lat = 0; stall_cnt = 0; got = 0;
    #1;
    if (bus.stall) stall_cnt++;
    while (lat < 60 && !got) begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      if (bus.valid) got = 1;
      else if (bus.stall) stall_cnt++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_res"}, 64'(bus.result), 64'(ref_model(op, a, b)));
    check({tag, "_rd"}, 64'(bus.rd_write_addr_out), 64'(rd));
    check({tag, "_stall_n"}, 64'(stall_cnt), 64'(elat));
    check({tag, "_stall_done"}, 64'(bus.stall), 64'(0));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(bus.valid), 64'(0));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return IMIN;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom();
    endcase
  endfunction

  int pulses;

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus.valid), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_rd", 64'(bus.rd_write_addr_out), 64'(0));
    check("rst_stall", 64'(bus.stall), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_op("mul_7_m3", 3'd0, 32'h7, 32'hFFFF_FFFD, 5'd3);
    run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    run_op("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
    run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'h2, 5'd7);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'h2, 5'd8);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd9);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd10);
    run_op("div_5_0", 3'd4, 32'd5, 32'd0, 5'd11);
    run_op("rem_5_0", 3'd6, 32'd5, 32'd0, 5'd12);
    run_op("div_ovf", 3'd4, IMIN, 32'hFFFF_FFFF, 5'd13);
    run_op("rem_ovf", 3'd6, IMIN, 32'hFFFF_FFFF, 5'd14);
    run_op("mulh_min", 3'd1, IMIN, IMIN, 5'd15);
    run_op("divu_min", 3'd5, IMIN, 32'h3, 5'd16);

    // Flush at iteration 10 of a MUL
    bus.op = 3'd0; bus.rs1_data = 32'h1234_5678; bus.rs2_data = 32'h9; bus.rd_write_addr = 5'd17;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_stall", 64'(bus.stall), 64'(0));
    check("flush_valid", 64'(bus.valid), 64'(0));
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid) pulses++;
    end
    check("flush_nopulse", 64'(pulses), 64'(0));
    run_op("after_flush", 3'd0, 32'h1234_5678, 32'h9, 5'd18);

    // flush wins over start in IDLE
    bus.op = 3'd0; bus.rs1_data = 32'h3; bus.rs2_data = 32'h3;
    bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    check("flush_prio_stall", 64'(bus.stall), 64'(0));
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    check("flush_prio_idle", 64'(bus.stall), 64'(0));
    @(negedge clk);

    // Reset in the middle of a divide
    bus.op = 3'd5; bus.rs1_data = 32'hDEAD_BEEF; bus.rs2_data = 32'h77; bus.rd_write_addr = 5'd19;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.valid), 64'(0));
    check("midrst_result", 64'(bus.result), 64'(0));
    check("midrst_rd", 64'(bus.rd_write_addr_out), 64'(0));
    check("midrst_stall", 64'(bus.stall), 64'(0));
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid) pulses++;
    end
    check("midrst_nopulse", 64'(pulses), 64'(0));

    // start pulsed during CALC must be ignored
    bus.op = 3'd6; bus.rs1_data = 32'hFFFF_FF9C; bus.rs2_data = 32'd7; bus.rd_write_addr = 5'd20;
    bus.start = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      bus.start = (c == 5);
      if (c == 5) begin
        bus.op = 3'd0; bus.rs1_data = 32'h5; bus.rs2_data = 32'h5; bus.rd_write_addr = 5'd21;
      end
      if (bus.valid) begin
        pulses++;
        check("ign_lat", 64'(c), 64'(XLEN + 1));
        check("ign_res", 64'(bus.result), 64'(ref_model(3'd6, 32'hFFFF_FF9C, 32'd7)));
        check("ign_rd", 64'(bus.rd_write_addr_out), 64'(20));
      end
    end
    check("ign_pulses", 64'(pulses), 64'(1));

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, 5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
